// File: rtl/pad_cfg_pkg.sv
// Shared types for the pad configuration controller: cfg bit layout and FSM states.
package pad_cfg_pkg;

    localparam int CFG_W  = 6;
    localparam int CFG_OE = 0;
    localparam int CFG_CS = 1;
    localparam int CFG_SL = 2;
    localparam int CFG_IE = 3;
    localparam int CFG_PU = 4;
    localparam int CFG_PD = 5;

    typedef struct packed {
        logic pd;
        logic pu;
        logic ie;
        logic sl;
        logic cs;
        logic oe;
    } pad_cfg_t;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_PH1,
        ST_PH2
    } pad_cfg_state_t;

endpackage

// File: rtl/pad_cfg_slot.sv
// Per-pad configuration register with two load phases so OE can only rise after
// strength/slew have already been applied.
module pad_cfg_slot
    import pad_cfg_pkg::*;
#(
    parameter pad_cfg_t RESET_VAL = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     ph1_en_i,
    input  logic     ph2_en_i,
    input  pad_cfg_t cfg_i,
    input  logic     oe_i,
    output pad_cfg_t cfg_o
);

    pad_cfg_t cfg_q, cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (ph1_en_i) begin
            cfg_d    = cfg_i;
            // OE may fall in phase 1 but never rise before phase 2
            cfg_d.oe = cfg_i.oe & cfg_q.oe;
        end else if (ph2_en_i) begin
            cfg_d.oe = oe_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_q <= RESET_VAL;
        else        cfg_q <= cfg_d;
    end

    assign cfg_o = cfg_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad-ring configuration owner: settle delay, two-phase writes, sticky lock, readback.
// state     | meaning
// ST_SETTLE | post-reset hold, writes refused
// ST_IDLE   | ready for a write
// ST_PH1    | CS/SL/IE/PU/PD applied, OE only allowed to fall
// ST_PH2    | new OE applied
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
#(
    parameter int NUM_BIDIR_PADS = 40,
    parameter int NUM_INPUT_PADS = 12,
    parameter int SETTLE_CYCLES  = 16,
    parameter bit RESET_IE       = 1'b1,
    localparam int NUM_PADS      = NUM_BIDIR_PADS + NUM_INPUT_PADS,
    localparam int AW            = $clog2(NUM_PADS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [CFG_W-1:0]          wr_data_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [CFG_W-1:0]          rd_data_o,
    input  logic                      lock_req_i,
    output logic                      locked_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu_o,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd_o,
    output logic [NUM_INPUT_PADS-1:0] input_pu_o,
    output logic [NUM_INPUT_PADS-1:0] input_pd_o
);

    localparam int       CW       = $clog2(SETTLE_CYCLES + 1);
    localparam pad_cfg_t BIDIR_RV = pad_cfg_t'({2'b00, RESET_IE, 3'b000});

    pad_cfg_state_t      state_q;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       addr_q;
    logic                oe_q;
    logic                locked_q;
    logic                err_q;
    logic                wr_ready_q;
    logic                busy_q;

    logic                accept;
    logic                wr_reject;
    pad_cfg_t            wr_cfg;
    pad_cfg_t            in_cfg;
    pad_cfg_t            slot_cfg [NUM_PADS];
    logic [NUM_PADS-1:0] ph1_en;
    logic [NUM_BIDIR_PADS-1:0] ph2_en;

    assign accept    = wr_valid_i & wr_ready_q;
    assign wr_reject = ({1'b0, wr_addr_i} >= (AW+1)'(NUM_PADS))
                     | (wr_data_i[CFG_PU] & wr_data_i[CFG_PD])
                     | locked_q;
    assign wr_cfg    = pad_cfg_t'(wr_data_i);
    // input pads only carry pull controls
    assign in_cfg    = pad_cfg_t'({wr_data_i[CFG_PD], wr_data_i[CFG_PU], 4'b0000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            oe_q       <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (wr_reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= ST_PH1;
                            addr_q     <= wr_addr_i;
                            oe_q       <= wr_data_i[CFG_OE];
                            wr_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_PH1: state_q <= ST_PH2;
                ST_PH2: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: state_q <= ST_SETTLE;
            endcase
            if (state_q != ST_SETTLE && lock_req_i) locked_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BIDIR_PADS; i++) begin : g_bidir
        assign ph1_en[i] = accept & ~wr_reject & (wr_addr_i == AW'(i));
        assign ph2_en[i] = (state_q == ST_PH1) & (addr_q == AW'(i));
        pad_cfg_slot #(.RESET_VAL(BIDIR_RV)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .ph1_en_i (ph1_en[i]),
            .ph2_en_i (ph2_en[i]),
            .cfg_i    (wr_cfg),
            .oe_i     (oe_q),
            .cfg_o    (slot_cfg[i])
        );
        assign bidir_oe_o[i] = slot_cfg[i].oe;
        assign bidir_cs_o[i] = slot_cfg[i].cs;
        assign bidir_sl_o[i] = slot_cfg[i].sl;
        assign bidir_ie_o[i] = slot_cfg[i].ie;
        assign bidir_pu_o[i] = slot_cfg[i].pu;
        assign bidir_pd_o[i] = slot_cfg[i].pd;
    end

    for (genvar j = 0; j < NUM_INPUT_PADS; j++) begin : g_input
        localparam int P = NUM_BIDIR_PADS + j;
        assign ph1_en[P] = accept & ~wr_reject & (wr_addr_i == AW'(P));
        pad_cfg_slot #(.RESET_VAL('0)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .ph1_en_i (ph1_en[P]),
            .ph2_en_i (1'b0),
            .cfg_i    (in_cfg),
            .oe_i     (1'b0),
            .cfg_o    (slot_cfg[P])
        );
        assign input_pu_o[j] = slot_cfg[P].pu;
        assign input_pd_o[j] = slot_cfg[P].pd;
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            if (rd_addr_i == AW'(k)) rd_data_o = slot_cfg[k];
        end
    end

    assign wr_ready_o = wr_ready_q;
    assign busy_o     = busy_q;
    assign locked_o   = locked_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: settle, two-phase writes, input pads, rejects, lock, async reset.
module tb_pad_cfg_ctrl;

    localparam int NB = 40;
    localparam int NI = 12;
    localparam int AW = 6;
    localparam logic [NB-1:0] ALL1 = {NB{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [5:0]    wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [5:0]    rd_data;
    logic          lock_req = 1'b0;
    logic          locked, busy, err;
    logic [NB-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic [NI-1:0] input_pu, input_pd;

    int n_checks = 0;
    int n_err    = 0;

    pad_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .lock_req_i (lock_req),
        .locked_o   (locked),
        .busy_o     (busy),
        .err_o      (err),
        .bidir_oe_o (bidir_oe),
        .bidir_cs_o (bidir_cs),
        .bidir_sl_o (bidir_sl),
        .bidir_ie_o (bidir_ie),
        .bidir_pu_o (bidir_pu),
        .bidir_pd_o (bidir_pd),
        .input_pu_o (input_pu),
        .input_pd_o (input_pd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        rd_addr = 6'd3;
        tick();
        tick();
        chk("rst_ready", 64'(wr_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ie", 64'(bidir_ie), 64'(ALL1));
        chk("rst_oe", 64'(bidir_oe), 64'd0);
        chk("rst_inpu", 64'(input_pu), 64'd0);
        chk("rst_rd3", 64'(rd_data), 64'h08);

        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("settle_ready", 64'(wr_ready), 64'd0);
        end
        tick();
        chk("settle_done_ready", 64'(wr_ready), 64'd1);
        chk("settle_done_busy", 64'(busy), 64'd0);

        // addr 3, 001111: OE rises only in PH2
        wr_addr = 6'd3; wr_data = 6'b001111; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("w3_ph1_cs", 64'(bidir_cs), 64'h8);
        chk("w3_ph1_sl", 64'(bidir_sl), 64'h8);
        chk("w3_ph1_oe", 64'(bidir_oe), 64'd0);
        chk("w3_ph1_rd", 64'(rd_data), 64'h0E);
        chk("w3_ph1_ready", 64'(wr_ready), 64'd0);
        tick();
        chk("w3_ph2_oe", 64'(bidir_oe), 64'h8);
        chk("w3_ph2_busy", 64'(busy), 64'd1);
        tick();
        chk("w3_done_ready", 64'(wr_ready), 64'd1);
        chk("w3_done_rd", 64'(rd_data), 64'h0F);

        // addr 3, 001000: OE falls already in PH1
        wr_data = 6'b001000; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("w3b_ph1_oe", 64'(bidir_oe), 64'd0);
        chk("w3b_ph1_cs", 64'(bidir_cs), 64'd0);
        chk("w3b_ph1_rd", 64'(rd_data), 64'h08);
        tick();
        chk("w3b_ph2_oe", 64'(bidir_oe), 64'd0);
        tick();
        chk("w3b_done_rd", 64'(rd_data), 64'h08);
        chk("w3b_done_ie", 64'(bidir_ie), 64'(ALL1));

        // input pad 1 (addr 41): only PU applied
        wr_addr = 6'd41; wr_data = 6'b010001; wr_valid = 1'b1; rd_addr = 6'd41;
        tick();
        wr_valid = 1'b0;
        chk("w41_inpu", 64'(input_pu), 64'h2);
        chk("w41_inpd", 64'(input_pd), 64'd0);
        chk("w41_oe", 64'(bidir_oe), 64'd0);
        chk("w41_pu", 64'(bidir_pu), 64'd0);
        chk("w41_ie", 64'(bidir_ie), 64'(ALL1));
        chk("w41_rd", 64'(rd_data), 64'h10);
        tick();
        chk("w41_ph2_ready", 64'(wr_ready), 64'd0);
        tick();
        chk("w41_done_ready", 64'(wr_ready), 64'd1);

        // out-of-range address
        wr_addr = 6'd52; wr_data = 6'b000001; wr_valid = 1'b1; rd_addr = 6'd52;
        tick();
        wr_valid = 1'b0;
        chk("rej52_err", 64'(err), 64'd1);
        chk("rej52_ready", 64'(wr_ready), 64'd1);
        chk("rej52_rd", 64'(rd_data), 64'd0);
        chk("rej52_oe", 64'(bidir_oe), 64'd0);
        tick();
        chk("rej52_err_clr", 64'(err), 64'd0);

        // PU and PD both set
        wr_addr = 6'd4; wr_data = 6'b110000; wr_valid = 1'b1; rd_addr = 6'd4;
        tick();
        wr_valid = 1'b0;
        chk("rejpp_err", 64'(err), 64'd1);
        chk("rejpp_rd", 64'(rd_data), 64'h08);
        chk("rejpp_pu", 64'(bidir_pu), 64'd0);
        chk("rejpp_pd", 64'(bidir_pd), 64'd0);
        tick();
        chk("rejpp_err_clr", 64'(err), 64'd0);

        // async reset in PH1 of addr 5 write
        wr_addr = 6'd5; wr_data = 6'b000111; wr_valid = 1'b1; rd_addr = 6'd5;
        tick();
        wr_valid = 1'b0;
        chk("w5_ph1_cs", 64'(bidir_cs), 64'h20);
        chk("w5_ph1_oe", 64'(bidir_oe), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", 64'(bidir_cs), 64'd0);
        chk("mid_rst_ie", 64'(bidir_ie), 64'(ALL1));
        chk("mid_rst_inpu", 64'(input_pu), 64'd0);
        chk("mid_rst_ready", 64'(wr_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd1);
        chk("mid_rst_rd5", 64'(rd_data), 64'h08);
        tick();
        rst_n = 1'b1;
        lock_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 9) lock_req = 1'b0;
            tick();
            chk("resettle_ready", 64'(wr_ready), 64'd0);
        end
        chk("settle_lock_ignored", 64'(locked), 64'd0);
        tick();
        chk("resettle_done_ready", 64'(wr_ready), 64'd1);

        // lock during an in-flight write: write completes, later writes rejected
        wr_addr = 6'd7; wr_data = 6'b000111; wr_valid = 1'b1; rd_addr = 6'd7;
        tick();
        wr_valid = 1'b0;
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        chk("lock_set", 64'(locked), 64'd1);
        chk("lock_w7_oe", 64'(bidir_oe), 64'h80);
        tick();
        chk("lock_w7_ready", 64'(wr_ready), 64'd1);
        wr_data = 6'b000000; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("lock_rej_err", 64'(err), 64'd1);
        chk("lock_rej_rd", 64'(rd_data), 64'h07);
        chk("lock_rej_oe", 64'(bidir_oe), 64'h80);
        tick();
        chk("lock_sticky", 64'(locked), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
